// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 8-bit CPU datapath.
// Every instruction spends one DECODE cycle and then one EXEC cycle or a
// MEM phase of one or more cycles. Control outputs are decoded
// combinationally from the current state and opCode. The unit also holds
// the architectural Z flag and detects HALT and memory-bus timeouts.
//
// Memory handshake (valid/ready): mem_req is the valid. It stays high in
// every MEM cycle until a cycle in which mem_ready is also high. That cycle
// completes the access on its closing clock edge. mem_req never drops
// while waiting, except after a timeout (FAULT) or an asynchronous reset.
// MemWrite_Enable qualifies a store for the whole MEM phase.
module cpu_control_fsm #(
  parameter int MEM_TIMEOUT = 16,  // MEM wait cycles before fault; 0 = wait forever
  parameter int CNT_W       = 5    // timeout counter width
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opCode,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       PC_Enable,
  output logic       RA_Enable,
  output logic       Reg_const4,
  output logic       RegWrite_Enable,
  output logic       Reg_Imm,
  output logic       MemWrite_Enable,
  output logic [1:0] PC_RA_ALU_REG,
  output logic [1:0] Alu_Move_Mem,
  output logic [1:0] Reg_4_PC,
  output logic [2:0] ALUOP,
  output logic       mem_req,
  output logic       z_flag,
  output logic       retire,
  output logic       halted,
  output logic       fault,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_DECODE = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_HALT   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // A MEM_TIMEOUT of zero turns the timeout off completely.
  localparam bit               TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = TIMEOUT_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_inc, cnt_clr;
  logic             z_load;

  assign fsm_state = state;

  // State register, architectural Z flag and MEM wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_DECODE;
      z_flag <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (z_load) z_flag <= zero_flag;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state and control decode from state, opCode, Z flag and mem_ready.
  always_comb begin
    state_next      = state;
    PC_Enable       = 1'b0;
    RA_Enable       = 1'b0;
    Reg_const4      = 1'b0;
    RegWrite_Enable = 1'b0;
    Reg_Imm         = 1'b0;
    MemWrite_Enable = 1'b0;
    PC_RA_ALU_REG   = 2'b00;
    Alu_Move_Mem    = 2'b00;
    Reg_4_PC        = 2'b00;
    ALUOP           = 3'b000;
    mem_req         = 1'b0;
    retire          = 1'b0;
    halted          = 1'b0;
    fault           = 1'b0;
    z_load          = 1'b0;
    cnt_inc         = 1'b0;
    cnt_clr         = 1'b0;

    case (state)
      S_DECODE: begin
        case (opCode)
          OP_LD, OP_ST: state_next = S_MEM;
          OP_HALT: begin
            // HALT finishes in DECODE, so it retires here.
            retire     = 1'b1;
            state_next = S_HALT;
          end
          default: state_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        PC_Enable  = 1'b1;
        retire     = 1'b1;
        state_next = S_DECODE;
        case (opCode)
          OP_NOP: ;
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            ALUOP           = 3'(opCode - OP_ADD);
            RegWrite_Enable = 1'b1;
            z_load          = 1'b1;
          end
          OP_ADDI: begin
            // r3 <= imm + r3: rd forced to r3, IN1 takes the immediate.
            Reg_const4      = 1'b1;
            Reg_Imm         = 1'b1;
            RegWrite_Enable = 1'b1;
            z_load          = 1'b1;
          end
          OP_MOV: begin
            RegWrite_Enable = 1'b1;
            Alu_Move_Mem    = 2'b01;
          end
          OP_CMP: begin
            ALUOP  = 3'b001;
            z_load = 1'b1;
          end
          OP_BEQ, OP_BNE: begin
            // The ALU forms PC + imm. It becomes the PC source only when taken.
            Reg_Imm  = 1'b1;
            Reg_4_PC = 2'b10;
            if ((opCode == OP_BEQ) == z_flag) PC_RA_ALU_REG = 2'b10;
          end
          OP_JMP: PC_RA_ALU_REG = 2'b11;
          OP_CALL: begin
            RA_Enable     = 1'b1;
            PC_RA_ALU_REG = 2'b11;
          end
          OP_RET: PC_RA_ALU_REG = 2'b01;
          default: ;
        endcase
      end

      S_MEM: begin
        mem_req         = 1'b1;
        MemWrite_Enable = (opCode == OP_ST);
        if (mem_ready) begin
          // A ready in the last allowed cycle still completes the access.
          PC_Enable  = 1'b1;
          retire     = 1'b1;
          cnt_clr    = 1'b1;
          state_next = S_DECODE;
          if (opCode == OP_LD) begin
            RegWrite_Enable = 1'b1;
            Alu_Move_Mem    = 2'b10;
          end
        end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
          cnt_clr    = 1'b1;
          state_next = S_FAULT;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_next = S_DECODE;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm. Each step drives the inputs on a
// falling edge, queues the control word expected in that cycle, and checks
// it shortly afterwards.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opCode;
  logic       zero_flag;
  logic       mem_ready;
  logic       PC_Enable, RA_Enable, Reg_const4, RegWrite_Enable, Reg_Imm, MemWrite_Enable;
  logic [1:0] PC_RA_ALU_REG, Alu_Move_Mem, Reg_4_PC;
  logic [2:0] ALUOP;
  logic       mem_req, z_flag, retire, halted, fault;
  logic [2:0] fsm_state;

  logic [19:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;

  cpu_control_fsm #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .PC_Enable(PC_Enable), .RA_Enable(RA_Enable),
    .Reg_const4(Reg_const4), .RegWrite_Enable(RegWrite_Enable), .Reg_Imm(Reg_Imm),
    .MemWrite_Enable(MemWrite_Enable), .PC_RA_ALU_REG(PC_RA_ALU_REG),
    .Alu_Move_Mem(Alu_Move_Mem), .Reg_4_PC(Reg_4_PC), .ALUOP(ALUOP),
    .mem_req(mem_req), .z_flag(z_flag), .retire(retire), .halted(halted),
    .fault(fault), .fsm_state(fsm_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  wire [19:0] obs = {PC_Enable, RA_Enable, Reg_const4, RegWrite_Enable, Reg_Imm,
                     MemWrite_Enable, PC_RA_ALU_REG, Alu_Move_Mem, Reg_4_PC, ALUOP,
                     mem_req, retire, halted, fault, z_flag};

  function automatic logic [19:0] ev(input logic pc, ra, c4, rw, imm, mw,
                                     input logic [1:0] prs, amm, r4,
                                     input logic [2:0] alu,
                                     input logic mreq, ret, hlt, flt, z);
    return {pc, ra, c4, rw, imm, mw, prs, amm, r4, alu, mreq, ret, hlt, flt, z};
  endfunction

  // Output word with everything idle except the Z flag.
  function automatic logic [19:0] idle(input logic z);
    return ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0,0,z);
  endfunction

  // Scoreboard: pop the oldest expectation and compare with the DUT now.
  task automatic check_out();
    logic [19:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  // Driver: call on a falling edge, returns on the next falling edge.
  task automatic step(input string tag, input logic [3:0] op, input logic zf,
                      input logic rdy, input logic [19:0] e);
    opCode    = op;
    zero_flag = zf;
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check_out();
    @(negedge clk);
  endtask

  // Assert reset for one cycle, check reset values, release on a falling edge.
  task automatic do_reset(input string tag);
    opCode    = 4'h7;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    reset     = 1'b0;
    exp_q.push_back(idle(1'b0));
    tag_q.push_back(tag);
    #1;
    check_out();
    total++;
    assert (fsm_state === 3'd0) else begin
      bad++;
      $error("FAIL %s_state observed=%0d expected=0", tag, fsm_state);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    opCode    = 4'h0;
    zero_flag = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    do_reset("reset0");

    // ALU ops and Z flag tracking.
    step("dec_add",  4'h1, 1, 0, idle(0));
    step("exe_add",  4'h1, 1, 0, ev(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,1,0,0,0));
    step("dec_sub",  4'h2, 0, 0, idle(1));
    step("exe_sub",  4'h2, 0, 0, ev(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b001,0,1,0,0,1));
    step("dec_cmp",  4'hE, 1, 0, idle(0));
    step("exe_cmp",  4'hE, 1, 0, ev(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b001,0,1,0,0,0));
    // Branches with Z=1: BEQ taken, BNE not taken.
    step("dec_beq1", 4'h9, 0, 0, idle(1));
    step("exe_beq1", 4'h9, 0, 0, ev(1,0,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,1,0,0,1));
    step("dec_bne1", 4'hD, 0, 0, idle(1));
    step("exe_bne1", 4'hD, 0, 0, ev(1,0,0,0,1,0,2'b00,2'b00,2'b10,3'b000,0,1,0,0,1));
    // MOV leaves Z alone.
    step("dec_mov",  4'h6, 0, 0, idle(1));
    step("exe_mov",  4'h6, 0, 0, ev(1,0,0,1,0,0,2'b00,2'b01,2'b00,3'b000,0,1,0,0,1));
    step("dec_cmp2", 4'hE, 0, 0, idle(1));
    step("exe_cmp2", 4'hE, 0, 0, ev(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b001,0,1,0,0,1));
    // Branches with Z=0: BEQ not taken, BNE taken.
    step("dec_beq0", 4'h9, 1, 0, idle(0));
    step("exe_beq0", 4'h9, 1, 0, ev(1,0,0,0,1,0,2'b00,2'b00,2'b10,3'b000,0,1,0,0,0));
    step("dec_bne0", 4'hD, 1, 0, idle(0));
    step("exe_bne0", 4'hD, 1, 0, ev(1,0,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,1,0,0,0));
    step("dec_addi", 4'h5, 1, 0, idle(0));
    step("exe_addi", 4'h5, 1, 0, ev(1,0,1,1,1,0,2'b00,2'b00,2'b00,3'b000,0,1,0,0,0));
    step("dec_call", 4'hB, 0, 0, idle(1));
    step("exe_call", 4'hB, 0, 0, ev(1,1,0,0,0,0,2'b11,2'b00,2'b00,3'b000,0,1,0,0,1));
    step("dec_ret",  4'hC, 0, 0, idle(1));
    step("exe_ret",  4'hC, 0, 0, ev(1,0,0,0,0,0,2'b01,2'b00,2'b00,3'b000,0,1,0,0,1));
    step("dec_jmp",  4'hA, 0, 0, idle(1));
    step("exe_jmp",  4'hA, 0, 0, ev(1,0,0,0,0,0,2'b11,2'b00,2'b00,3'b000,0,1,0,0,1));
    step("dec_nop",  4'h0, 0, 0, idle(1));
    step("exe_nop",  4'h0, 0, 0, ev(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1,0,0,1));
    step("dec_or",   4'h4, 0, 0, idle(1));
    step("exe_or",   4'h4, 0, 0, ev(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b011,0,1,0,0,1));
    step("dec_and",  4'h3, 1, 0, idle(0));
    step("exe_and",  4'h3, 1, 0, ev(1,0,0,1,0,0,2'b00,2'b00,2'b00,3'b010,0,1,0,0,0));

    // LD, ready on the third MEM cycle.
    step("dec_ld",   4'h7, 0, 0, idle(1));
    step("ld_mem1",  4'h7, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0,0,0,1));
    step("ld_mem2",  4'h7, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0,0,0,1));
    step("ld_mem3",  4'h7, 0, 1, ev(1,0,0,1,0,0,2'b00,2'b10,2'b00,3'b000,1,1,0,0,1));

    // ST, ready on the last permitted (4th) cycle: no fault.
    step("dec_st1",  4'h8, 0, 0, idle(1));
    for (int i = 0; i < 3; i++)
      step("st1_wait", 4'h8, 0, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0,0,0,1));
    step("st1_last", 4'h8, 0, 1, ev(1,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,1,0,0,1));

    // ST with no ready: four MEM cycles, then sticky fault.
    step("dec_st2",  4'h8, 0, 0, idle(1));
    for (int i = 0; i < 4; i++)
      step("st2_wait", 4'h8, 0, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0,0,0,1));
    for (int i = 0; i < 5; i++)
      step("fault", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,0,1,1));

    do_reset("reset1");

    // HALT retires in DECODE, then stays halted.
    step("dec_halt", 4'hF, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1,0,0,0));
    for (int i = 0; i < 20; i++)
      step("halt", 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0,1,0,0));

    do_reset("reset2");

    // Reset in the middle of a LD drops the bus request at once.
    step("dec_ld2",  4'h7, 0, 0, idle(0));
    step("ld2_mem1", 4'h7, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,0,0,0,0));
    opCode    = 4'h7;
    mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    exp_q.push_back(idle(0));
    tag_q.push_back("async_rst");
    #1;
    check_out();
    @(negedge clk);
    reset = 1'b1;
    step("dec_nop2", 4'h0, 0, 0, idle(0));
    step("exe_nop2", 4'h0, 0, 0, ev(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1,0,0,0));

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_empty observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
